// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchroniser, glitch filter, edge strobes and glitch counter for an async pin
module input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int GLITCH_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    in,
    input  logic                    glitch_clr,
    output logic                    out,
    output logic                    rise,
    output logic                    fall,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        PEND_H = 2'd1,
        HIGH   = 2'd2,
        PEND_L = 2'd3
    } state_t;

    // Last sample index of an accepted run; with a one-sample filter the PEND states are skipped.
    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);
    localparam bit         ONE_SHOT = (FILTER_CYCLES == 1);
    localparam logic [GLITCH_WIDTH-1:0] GC_MAX = {GLITCH_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [7:0]             cnt;
    logic                   glitch_hit;

    assign s = sync_q[SYNC_STAGES-1];

    // A pending run that breaks before acceptance is exactly one rejected pulse.
    assign glitch_hit = ((state == PEND_H) && !s) || ((state == PEND_L) && s);

    // Plain flop chain into the clock domain, nothing between stages.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Filter FSM: a level change is accepted after FILTER_CYCLES identical synchronised samples.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= LOW;
            cnt   <= 8'd0;
            out   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                LOW: begin
                    if (s) begin
                        if (ONE_SHOT) begin
                            state <= HIGH;
                            out   <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            cnt   <= 8'd1;
                            state <= PEND_H;
                        end
                    end
                end
                PEND_H: begin
                    if (!s) begin
                        state <= LOW;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH;
                        out   <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        if (ONE_SHOT) begin
                            state <= LOW;
                            out   <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt   <= 8'd1;
                            state <= PEND_L;
                        end
                    end
                end
                PEND_L: begin
                    if (s) begin
                        state <= HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW;
                        out   <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= LOW;
                    out   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating rejected-pulse counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            glitch_count <= '0;
        end else if (glitch_clr) begin
            glitch_count <= '0;
        end else if (glitch_hit && (glitch_count != GC_MAX)) begin
            glitch_count <= glitch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner across three parameter sets
module tb_input_conditioner;

    typedef struct packed {
        logic [2:0]       o;
        logic [2:0]       r;
        logic [2:0]       f;
        logic [2:0][15:0] g;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic in_sig = 1'b0;
    logic clr = 1'b0;

    logic [2:0] d_out, d_rise, d_fall;
    logic [7:0] gc0;
    logic [1:0] gc1;
    logic [7:0] gc2;
    logic [2:0][15:0] act_g;

    assign act_g = {16'(gc2), 16'(gc1), 16'(gc0)};

    always #5 clk = ~clk;

    input_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .GLITCH_WIDTH(8)) dut0 (
        .clk(clk), .n_reset(n_reset), .in(in_sig), .glitch_clr(clr),
        .out(d_out[0]), .rise(d_rise[0]), .fall(d_fall[0]), .glitch_count(gc0));

    input_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .GLITCH_WIDTH(2)) dut1 (
        .clk(clk), .n_reset(n_reset), .in(in_sig), .glitch_clr(clr),
        .out(d_out[1]), .rise(d_rise[1]), .fall(d_fall[1]), .glitch_count(gc1));

    input_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .GLITCH_WIDTH(8)) dut2 (
        .clk(clk), .n_reset(n_reset), .in(in_sig), .glitch_clr(clr),
        .out(d_out[2]), .rise(d_rise[2]), .fall(d_fall[2]), .glitch_count(gc2));

    localparam int SN [3] = '{2, 2, 2};
    localparam int FN [3] = '{4, 4, 1};
    localparam int GM [3] = '{255, 3, 255};

    bit   cap[$];
    exp_t exp_q[$];
    int   k = 0;
    int   r_edge = -1;
    bit   m_out [3];
    int   m_gc  [3];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mon_cycle = 0;

    // Synchronised level seen by the filter at edge kk: the pin as captured SYNC_STAGES edges earlier, 0 if that predates the last reset.
    function automatic bit s_at(int i, int kk);
        int j;
        j = kk - SN[i];
        if (j <= r_edge || j < 0) return 1'b0;
        return cap[j];
    endfunction

    task automatic model_edge();
        exp_t e;
        bit   o, flip, glitch;
        e = '0;
        cap.push_back(in_sig);
        if (!n_reset) begin
            r_edge = k;
            for (int i = 0; i < 3; i++) begin
                m_out[i] = 1'b0;
                m_gc[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = m_out[i];
                flip = 1'b1;
                for (int t = 0; t < FN[i]; t++)
                    if (s_at(i, k - t) == o) flip = 1'b0;
                glitch = !flip && (s_at(i, k) == o) && (s_at(i, k - 1) != o);
                if (clr) m_gc[i] = 0;
                else if (glitch && m_gc[i] < GM[i]) m_gc[i] = m_gc[i] + 1;
                if (flip) m_out[i] = !o;
                e.r[i] = flip && !o;
                e.f[i] = flip && o;
            end
        end
        for (int i = 0; i < 3; i++) begin
            e.o[i] = m_out[i];
            e.g[i] = 16'(m_gc[i]);
        end
        exp_q.push_back(e);
        k++;
    endtask

    task automatic step(input bit i_in, input bit i_clr, input bit i_rst_n);
        @(negedge clk);
        in_sig  = i_in;
        clr     = i_clr;
        n_reset = i_rst_n;
        model_edge();
    endtask

    task automatic run(input bit lvl, input int n);
        for (int c = 0; c < n; c++) step(lvl, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int i, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s[dut%0d] cycle %0d: got %0d expected %0d", name, i, mon_cycle, act, expv);
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after that edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk("out", i, int'(d_out[i]), int'(e.o[i]));
                    chk("rise", i, int'(d_rise[i]), int'(e.r[i]));
                    chk("fall", i, int'(d_fall[i]), int'(e.f[i]));
                    chk("glitch_count", i, int'(act_g[i]), int'(e.g[i]));
                end
                mon_cycle++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit lvl;
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0);
        run(1'b0, 20);
        // single accepted 10-cycle pulse
        run(1'b1, 10);
        run(1'b0, 15);
        // short pulse, then a short dip inside a long high level
        run(1'b1, 3);
        run(1'b0, 12);
        run(1'b1, 12);
        run(1'b0, 3);
        run(1'b1, 12);
        run(1'b0, 15);
        // five 1-cycle glitches, then a sixth with the clear on its increment edge
        for (int g = 0; g < 5; g++) begin
            run(1'b1, 1);
            run(1'b0, 5);
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run(1'b0, 5);
        // reset while the default filter is mid-count
        run(1'b1, 4);
        step(1'b1, 1'b0, 1'b0);
        run(1'b1, 12);
        run(1'b0, 15);
        // toggle every two cycles
        for (int t = 0; t < 8; t++) run(t[0] ? 1'b0 : 1'b1, 2);
        run(1'b0, 10);
        // randomized runs with occasional clears and resets
        lvl = 1'b0;
        for (int b = 0; b < 300; b++) begin
            int len;
            lvl = ~lvl;
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++)
                step(lvl, ($urandom_range(0, 19) == 0), ($urandom_range(0, 249) != 0));
        end
        run(1'b0, 12);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
